core_mem_arbiter: RTL

Shares the core's single system bus between the instruction-fetch port and the load/store port. Each accepted request is decoded against the peripheral map: boot ROM, UART and PLIC. The block then runs one bus transaction at a time and routes the response back to the requester that issued it. Unmapped addresses and writes to the boot ROM get an error response without touching the bus. The block sits between the core datapath and the peripheral slaves, replacing the direct fetch-to-ROM connection.

---
 rtl/core_mem_arbiter_if.sv | 49 ++++
 rtl/core_mem_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: groups the fetch, load/store and system-bus signals of the memory arbiter
//   fetch port      : if_req_valid/ready/addr, if_rsp_valid/rdata/err
//   load/store port : ls_req_valid/ready/addr/we/wdata/be, ls_rsp_valid/rdata/err
//   system bus      : bus_req_valid/ready/addr/wdata/we/be/sel, bus_rsp_valid/rdata
//   slave modport   : arbiter side; master modport: requesters and peripheral slaves
interface core_mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [XLEN-1:0]   if_req_addr;
    logic              if_rsp_valid;
    logic [XLEN-1:0]   if_rsp_rdata;
    logic              if_rsp_err;
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [XLEN-1:0]   ls_req_addr;
    logic              ls_req_we;
    logic [XLEN-1:0]   ls_req_wdata;
    logic [XLEN/8-1:0] ls_req_be;
    logic              ls_rsp_valid;
    logic [XLEN-1:0]   ls_rsp_rdata;
    logic              ls_rsp_err;
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [XLEN-1:0]   bus_req_addr;
    logic [XLEN-1:0]   bus_req_wdata;
    logic              bus_req_we;
    logic [XLEN/8-1:0] bus_req_be;
    logic [2:0]        bus_req_sel;
    logic              bus_rsp_valid;
    logic [XLEN-1:0]   bus_rsp_rdata;
    modport slave (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_be,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        output bus_req_valid, bus_req_addr, bus_req_wdata, bus_req_we, bus_req_be, bus_req_sel
    );
    modport master (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_be,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
        input  bus_req_valid, bus_req_addr, bus_req_wdata, bus_req_we, bus_req_be, bus_req_sel
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one system bus between instruction fetch and load/store
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   mem   : slave modport carrying both requester ports and the system bus
//   Load/store wins arbitration unless fetch has waited MAX_WAIT load/store grants.
//   Accepted requests are decoded to ROM/UART/PLIC; misses and ROM writes get an
//   error response without a bus cycle. One transaction is outstanding at a time.
module core_mem_arbiter #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] BOOTROM_BASE  = 32'h8000_0000,
    parameter logic [XLEN-1:0] BOOTROM_RANGE = 32'h0000_1000,
    parameter logic [XLEN-1:0] UART_BASE     = 32'h1000_0000,
    parameter logic [XLEN-1:0] UART_RANGE    = 32'h0000_1000,
    parameter logic [XLEN-1:0] PLIC_BASE     = 32'h0C00_0000,
    parameter logic [XLEN-1:0] PLIC_RANGE    = 32'h0000_1000,
    parameter int              MAX_WAIT      = 4
) (
    input logic               clk,
    input logic               rst_n,
    core_mem_arbiter_if.slave mem
);
    localparam int SW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;
    state_t            state_q;
    logic              owner_q;
    logic [XLEN-1:0]   addr_q, wdata_q, if_rdata_q, ls_rdata_q;
    logic              we_q, bus_valid_q, if_valid_q, ls_valid_q, if_err_q, ls_err_q;
    logic [XLEN/8-1:0] be_q;
    logic [2:0]        sel_q, sel_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              ls_win, idle, ls_acc, if_acc, acc_we, rsp_fire, rsp_err;
    logic [XLEN-1:0]   acc_addr, rsp_data;
    // extra top bit keeps the subtraction from wrapping near the top of the map
    function automatic logic hit(input logic [XLEN-1:0] a, input logic [XLEN-1:0] base,
                                 input logic [XLEN-1:0] range);
        logic [XLEN:0] off;
        off = {1'b0, a} - {1'b0, base};
        return ({1'b0, a} >= {1'b0, base}) && (off < {1'b0, range});
    endfunction
    always_comb begin
        ls_win   = mem.ls_req_valid && !(mem.if_req_valid && starve_q == SW'(MAX_WAIT));
        idle     = rst_n && state_q == IDLE;
        ls_acc   = idle && ls_win;
        if_acc   = idle && mem.if_req_valid && !ls_win;
        acc_addr = ls_win ? mem.ls_req_addr : mem.if_req_addr;
        acc_we   = ls_win && mem.ls_req_we;
        sel_d    = {hit(acc_addr, PLIC_BASE, PLIC_RANGE), hit(acc_addr, UART_BASE, UART_RANGE),
                    hit(acc_addr, BOOTROM_BASE, BOOTROM_RANGE) && !acc_we};
        starve_d = if_acc ? '0 :
                   (ls_acc && mem.if_req_valid && starve_q != SW'(MAX_WAIT)) ? starve_q + SW'(1) :
                   starve_q;
        rsp_fire = (state_q == RSP && mem.bus_rsp_valid) || state_q == ERR;
        rsp_err  = state_q == ERR;
        rsp_data = rsp_err ? '0 : mem.bus_rsp_rdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            sel_q       <= '0;
            bus_valid_q <= 1'b0;
            starve_q    <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_valid_q  <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            if_valid_q <= rsp_fire && !owner_q;
            ls_valid_q <= rsp_fire && owner_q;
            if (rsp_fire && !owner_q) begin
                if_rdata_q <= rsp_data;
                if_err_q   <= rsp_err;
            end
            if (rsp_fire && owner_q) begin
                ls_rdata_q <= rsp_data;
                ls_err_q   <= rsp_err;
            end
            case (state_q)
                IDLE: if (ls_acc || if_acc) begin
                    owner_q     <= ls_acc;
                    addr_q      <= acc_addr;
                    we_q        <= acc_we;
                    wdata_q     <= ls_acc ? mem.ls_req_wdata : '0;
                    be_q        <= ls_acc ? mem.ls_req_be : '1;
                    sel_q       <= sel_d;
                    bus_valid_q <= |sel_d;
                    state_q     <= |sel_d ? REQ : ERR;
                end
                REQ: if (mem.bus_req_ready) begin
                    bus_valid_q <= 1'b0;
                    sel_q       <= '0;
                    state_q     <= RSP;
                end
                RSP: if (mem.bus_rsp_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem.if_req_ready  = if_acc;
    assign mem.ls_req_ready  = ls_acc;
    assign mem.if_rsp_valid  = if_valid_q;
    assign mem.if_rsp_rdata  = if_rdata_q;
    assign mem.if_rsp_err    = if_err_q;
    assign mem.ls_rsp_valid  = ls_valid_q;
    assign mem.ls_rsp_rdata  = ls_rdata_q;
    assign mem.ls_rsp_err    = ls_err_q;
    assign mem.bus_req_valid = bus_valid_q;
    assign mem.bus_req_addr  = addr_q;
    assign mem.bus_req_wdata = wdata_q;
    assign mem.bus_req_we    = we_q;
    assign mem.bus_req_be    = be_q;
    assign mem.bus_req_sel   = sel_q;
endmodule
